// File: rtl/mp3_frame_pkg.sv
// rtl/mp3_frame_pkg.sv - shared region tags and MP3 frame layout constants
package mp3_frame_pkg;

   typedef enum logic [2:0] {
      R_NONE        = 3'd0,
      R_HDR         = 3'd1,
      R_CRC         = 3'd2,
      R_SIDE_MONO   = 3'd3,
      R_SIDE_STEREO = 3'd4,
      R_MAIN        = 3'd5
   } region_t;

   localparam int         HDR_LEN     = 4;
   localparam int         CRC_LEN     = 2;
   localparam int         SIDE_MONO   = 17;
   localparam int         SIDE_STEREO = 32;
   localparam logic [7:0] SYNC_BYTE   = 8'hFF;
   localparam logic [1:0] MODE_MONO   = 2'd3;

endpackage

// File: rtl/sector_fetcher.sv
// rtl/sector_fetcher.sv - issues throttled SD sector reads and counts bytes per sector
module sector_fetcher #(
   parameter int SECTOR_BYTES = 512,
   parameter int ADDR_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] num_sectors,
   input  logic              sd_ready,
   input  logic              fifo_almost_full,
   input  logic              sd_iv,
   output logic              sd_rd,
   output logic [ADDR_W-1:0] sd_addr,
   output logic              busy,
   output logic              byte_acc,
   output logic              start_acc
);

   typedef enum logic [1:0] {F_IDLE, F_ARM, F_STREAM} fetch_state_t;
   localparam int BW = $clog2(SECTOR_BYTES);

   fetch_state_t      r_state;
   logic [ADDR_W-1:0] r_base;
   logic [ADDR_W-1:0] r_count;
   logic [ADDR_W-1:0] r_idx;
   logic [ADDR_W-1:0] r_sd_addr;
   logic [BW-1:0]     r_byte_cnt;
   logic              r_sd_rd;
   logic              r_busy;

   // Bytes outside STREAM belong to no requested sector (e.g. after a reset) and are dropped.
   assign byte_acc  = sd_iv && (r_state == F_STREAM);
   assign start_acc = start && (r_state == F_IDLE) && (num_sectors != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= F_IDLE;
         r_base     <= '0;
         r_count    <= '0;
         r_idx      <= '0;
         r_sd_addr  <= '0;
         r_byte_cnt <= '0;
         r_sd_rd    <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_sd_rd <= 1'b0;
         case (r_state)
            F_IDLE: begin
               if (start_acc) begin
                  r_base     <= base_addr;
                  r_count    <= num_sectors;
                  r_idx      <= '0;
                  r_byte_cnt <= '0;
                  r_busy     <= 1'b1;
                  r_state    <= F_ARM;
               end
            end
            F_ARM: begin
               if (sd_ready && !fifo_almost_full) begin
                  r_sd_rd   <= 1'b1;
                  r_sd_addr <= r_base + r_idx;
                  r_state   <= F_STREAM;
               end
            end
            F_STREAM: begin
               if (sd_iv) begin
                  r_byte_cnt <= r_byte_cnt + 1'b1;
                  if (r_byte_cnt == BW'(SECTOR_BYTES - 1)) begin
                     r_idx <= r_idx + 1'b1;
                     if (r_idx + 1'b1 == r_count) begin
                        r_state <= F_IDLE;
                        r_busy  <= 1'b0;
                     end else begin
                        r_state <= F_ARM;
                     end
                  end
               end
            end
            default: r_state <= F_IDLE;
         endcase
      end
   end

   assign sd_rd   = r_sd_rd;
   assign sd_addr = r_sd_addr;
   assign busy    = r_busy;

endmodule

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - MP3 frame sync hunt and region tagging over the SD byte stream
module frame_sequencer
   import mp3_frame_pkg::*;
#(
   parameter int SECTOR_BYTES = 512,
   parameter int ADDR_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] num_sectors,
   input  logic              sd_ready,
   output logic              sd_rd,
   output logic [ADDR_W-1:0] sd_addr,
   input  logic              sd_iv,
   input  logic [7:0]        sd_din,
   input  logic              header_iv,
   input  logic              prot,
   input  logic [1:0]        mode,
   input  logic [10:0]       frame_size,
   input  logic              fifo_almost_full,
   output logic [7:0]        d_out,
   output logic              d_ov,
   output logic [2:0]        region,
   output logic              frame_done,
   output logic              sync_lost,
   output logic              busy
);

   typedef enum logic [2:0] {
      S_SEARCH, S_SYNC2, S_HDR, S_WAIT_HDR, S_CRC, S_SIDE, S_MAIN
   } frame_state_t;

   logic        w_byte;
   logic        w_start_acc;
   logic [10:0] w_crc_len;
   logic [10:0] w_side_len;
   logic [10:0] w_overhead;
   logic [10:0] w_main_len;

   frame_state_t r_state;
   logic [7:0]   r_prev;
   logic [10:0]  r_cnt;
   logic [10:0]  r_side_len;
   logic [10:0]  r_main_len;
   logic         r_mono;
   logic [7:0]   r_d_out;
   logic         r_d_ov;
   region_t      r_region;
   logic         r_frame_done;
   logic         r_sync_lost;

   sector_fetcher #(.SECTOR_BYTES(SECTOR_BYTES), .ADDR_W(ADDR_W)) u_fetch (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .num_sectors(num_sectors), .sd_ready(sd_ready),
      .fifo_almost_full(fifo_almost_full), .sd_iv(sd_iv),
      .sd_rd(sd_rd), .sd_addr(sd_addr), .busy(busy),
      .byte_acc(w_byte), .start_acc(w_start_acc)
   );

   assign w_crc_len  = prot ? 11'd0 : 11'(CRC_LEN);
   assign w_side_len = (mode == MODE_MONO) ? 11'(SIDE_MONO) : 11'(SIDE_STEREO);
   assign w_overhead = 11'(HDR_LEN) + w_crc_len + w_side_len;
   assign w_main_len = frame_size - w_overhead;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_SEARCH;
         r_prev       <= '0;
         r_cnt        <= '0;
         r_side_len   <= '0;
         r_main_len   <= '0;
         r_mono       <= 1'b0;
         r_d_out      <= '0;
         r_d_ov       <= 1'b0;
         r_region     <= R_NONE;
         r_frame_done <= 1'b0;
         r_sync_lost  <= 1'b0;
      end else begin
         r_d_ov       <= 1'b0;
         r_region     <= R_NONE;
         r_frame_done <= 1'b0;
         r_sync_lost  <= 1'b0;
         if (w_start_acc) begin
            r_state <= S_SEARCH;
            r_prev  <= '0;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               S_SEARCH: begin
                  if (w_byte) begin
                     r_prev <= sd_din;
                     if (r_prev == SYNC_BYTE && sd_din[7:5] == 3'b111) begin
                        r_d_out  <= SYNC_BYTE;
                        r_d_ov   <= 1'b1;
                        r_region <= R_HDR;
                        r_state  <= S_SYNC2;
                     end
                  end
               end
               // r_prev holds the second sync byte; it goes out one cycle behind the first.
               S_SYNC2: begin
                  r_d_out  <= r_prev;
                  r_d_ov   <= 1'b1;
                  r_region <= R_HDR;
                  r_cnt    <= 11'd2;
                  r_state  <= S_HDR;
               end
               S_HDR: begin
                  if (w_byte) begin
                     // Counts 0 and 1 only occur when verifying the sync of a follow-on frame.
                     if ((r_cnt == 11'd0 && sd_din != SYNC_BYTE) ||
                         (r_cnt == 11'd1 && sd_din[7:5] != 3'b111)) begin
                        r_sync_lost <= 1'b1;
                        r_prev      <= sd_din;
                        r_state     <= S_SEARCH;
                     end else begin
                        r_d_out  <= sd_din;
                        r_d_ov   <= 1'b1;
                        r_region <= R_HDR;
                        r_cnt    <= r_cnt + 1'b1;
                        if (r_cnt == 11'(HDR_LEN - 1)) r_state <= S_WAIT_HDR;
                     end
                  end
               end
               S_WAIT_HDR: begin
                  if (w_byte) begin
                     r_sync_lost <= 1'b1;
                     r_prev      <= sd_din;
                     r_state     <= S_SEARCH;
                  end else if (header_iv) begin
                     if (frame_size < w_overhead) begin
                        r_sync_lost <= 1'b1;
                        r_prev      <= '0;
                        r_state     <= S_SEARCH;
                     end else begin
                        r_side_len <= w_side_len;
                        r_main_len <= w_main_len;
                        r_mono     <= (mode == MODE_MONO);
                        r_cnt      <= '0;
                        r_state    <= (w_crc_len == 11'd0) ? S_SIDE : S_CRC;
                     end
                  end
               end
               S_CRC: begin
                  if (w_byte) begin
                     r_d_out  <= sd_din;
                     r_d_ov   <= 1'b1;
                     r_region <= R_CRC;
                     if (r_cnt == 11'(CRC_LEN - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_SIDE;
                     end else begin
                        r_cnt <= r_cnt + 1'b1;
                     end
                  end
               end
               S_SIDE: begin
                  if (w_byte) begin
                     r_d_out  <= sd_din;
                     r_d_ov   <= 1'b1;
                     r_region <= r_mono ? R_SIDE_MONO : R_SIDE_STEREO;
                     if (r_cnt == r_side_len - 1'b1) begin
                        r_cnt <= '0;
                        if (r_main_len == 11'd0) begin
                           r_frame_done <= 1'b1;
                           r_state      <= S_HDR;
                        end else begin
                           r_state <= S_MAIN;
                        end
                     end else begin
                        r_cnt <= r_cnt + 1'b1;
                     end
                  end
               end
               S_MAIN: begin
                  if (w_byte) begin
                     r_d_out  <= sd_din;
                     r_d_ov   <= 1'b1;
                     r_region <= R_MAIN;
                     if (r_cnt == r_main_len - 1'b1) begin
                        r_cnt        <= '0;
                        r_frame_done <= 1'b1;
                        r_state      <= S_HDR;
                     end else begin
                        r_cnt <= r_cnt + 1'b1;
                     end
                  end
               end
               default: r_state <= S_SEARCH;
            endcase
         end
      end
   end

   assign d_out      = r_d_out;
   assign d_ov       = r_d_ov;
   assign region     = r_region;
   assign frame_done = r_frame_done;
   assign sync_lost  = r_sync_lost;

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - scoreboard bench for frame_sequencer
module tb_frame_sequencer;

   logic        clk = 1'b0;
   logic        rst, start, sd_ready, sd_rd, sd_iv, header_iv, prot, fifo_almost_full;
   logic [31:0] base_addr, num_sectors, sd_addr;
   logic [7:0]  sd_din, d_out;
   logic [1:0]  mode;
   logic [10:0] frame_size;
   logic        d_ov, frame_done, sync_lost, busy;
   logic [2:0]  region;

   frame_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .num_sectors(num_sectors), .sd_ready(sd_ready), .sd_rd(sd_rd),
      .sd_addr(sd_addr), .sd_iv(sd_iv), .sd_din(sd_din), .header_iv(header_iv),
      .prot(prot), .mode(mode), .frame_size(frame_size),
      .fifo_almost_full(fifo_almost_full), .d_out(d_out), .d_ov(d_ov),
      .region(region), .frame_done(frame_done), .sync_lost(sync_lost), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic [2:0] r;
      logic       done;
   } exp_t;

   exp_t        q[$];
   exp_t        e;
   logic [31:0] rd_q[$];
   int          n_assert = 0;
   int          n_fail   = 0;
   int          sl_cnt   = 0;
   int          pos;
   logic [31:0] base;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Scoreboard side: every forwarded byte must match the head of the expectation queue.
   always @(negedge clk) begin
      if (sd_rd === 1'b1) rd_q.push_back(sd_addr);
      if (sync_lost === 1'b1) sl_cnt++;
      if (d_ov === 1'b1) begin
         chk("d_ov_expected", 32'(q.size() != 0), 32'd1);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("d_out", 32'(d_out), 32'(e.d));
            chk("region", 32'(region), 32'(e.r));
            chk("frame_done", 32'(frame_done), 32'(e.done));
         end
      end else if (frame_done !== 1'b0 && !rst) begin
         chk("frame_done_without_d_ov", 32'(frame_done), 32'd0);
      end
   end

   initial begin
      #2000000;
      $error("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic ex(input logic [7:0] d, input logic [2:0] r, input logic done);
      exp_t t;
      t.d = d; t.r = r; t.done = done;
      q.push_back(t);
   endtask

   task automatic wait_rd(input logic [31:0] exp_addr);
      int n = 0;
      while (rd_q.size() == 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("sd_rd_seen", 32'(rd_q.size() != 0), 32'd1);
      if (rd_q.size() != 0) chk("sd_addr", rd_q.pop_front(), exp_addr);
   endtask

   task automatic sd_byte(input logic [7:0] b);
      if (pos % 512 == 0) wait_rd(base + 32'(pos / 512));
      @(negedge clk);
      sd_din = b;
      sd_iv  = 1'b1;
      @(negedge clk);
      sd_iv = 1'b0;
      repeat (3) @(negedge clk);
      pos++;
   endtask

   task automatic fb(input logic [7:0] b, input logic [2:0] r, input logic done);
      ex(b, r, done);
      sd_byte(b);
   endtask

   task automatic search_sync();
      ex(8'hFF, 3'd1, 1'b0);
      ex(8'hFB, 3'd1, 1'b0);
      sd_byte(8'hFF);
      sd_byte(8'hFB);
      fb(8'h90, 3'd1, 1'b0);
      fb(8'h44, 3'd1, 1'b0);
   endtask

   task automatic verify_hdr();
      fb(8'hFF, 3'd1, 1'b0);
      fb(8'hFB, 3'd1, 1'b0);
      fb(8'h90, 3'd1, 1'b0);
      fb(8'h44, 3'd1, 1'b0);
   endtask

   task automatic hdr(input logic p, input logic [1:0] m, input logic [10:0] fs);
      @(negedge clk);
      header_iv = 1'b1; prot = p; mode = m; frame_size = fs;
      @(negedge clk);
      header_iv = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic body(input int crc_n, input int side_n, input logic [2:0] side_r, input int main_n);
      for (int i = 0; i < crc_n; i++) fb(8'(8'hC0 + i), 3'd2, 1'b0);
      for (int i = 0; i < side_n; i++) fb(8'($urandom), side_r, (main_n == 0) && (i == side_n - 1));
      for (int i = 0; i < main_n; i++) fb(8'($urandom), 3'd5, i == main_n - 1);
   endtask

   task automatic pulse_start(input logic [31:0] b, input logic [31:0] n);
      @(negedge clk);
      start = 1'b1; base_addr = b; num_sectors = n;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; sd_ready = 1'b1; sd_iv = 1'b0; sd_din = 8'h00;
      header_iv = 1'b0; prot = 1'b0; mode = 2'd0; frame_size = 11'd0;
      fifo_almost_full = 1'b0; base_addr = 32'd0; num_sectors = 32'd0;
      pos = 0; base = 32'd0;
      repeat (3) @(negedge clk);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_sd_rd", 32'(sd_rd), 32'd0);
      chk("reset_sd_addr", sd_addr, 32'd0);
      chk("reset_d_ov", 32'(d_ov), 32'd0);
      chk("reset_region", 32'(region), 32'd0);
      rst = 1'b0;

      pulse_start(32'd100, 32'd3);
      base = 32'd100; pos = 0;
      chk("busy_after_start", 32'(busy), 32'd1);

      // Frame 1 found by search: stereo, no CRC, 417 bytes.
      sd_byte(8'h00);
      search_sync();
      hdr(1'b1, 2'd0, 11'd417);
      body(0, 32, 3'd4, 381);

      pulse_start(32'd500, 32'd7);

      // Frame 2 verified: mono with CRC, 208 bytes, crosses the first sector boundary.
      verify_hdr();
      hdr(1'b0, 2'd3, 11'd208);
      body(2, 17, 3'd3, 185);

      // Frame 3: frame_size too small for its overhead.
      verify_hdr();
      hdr(1'b0, 2'd0, 11'd30);
      chk("sync_lost_short_frame", 32'(sl_cnt), 32'd1);
      sd_byte(8'h12);
      sd_byte(8'h34);

      // Frame 4: reacquired, main_len zero so frame_done rides the last side byte.
      search_sync();
      hdr(1'b1, 2'd3, 11'd21);
      body(0, 17, 3'd3, 0);

      // Frame 5: bad second sync byte, reacquire, then a byte arrives before the header result.
      fb(8'hFF, 3'd1, 1'b0);
      sd_byte(8'h7F);
      chk("sync_lost_bad_sync", 32'(sl_cnt), 32'd2);
      search_sync();
      sd_byte(8'h55);
      chk("sync_lost_wait_hdr", 32'(sl_cnt), 32'd3);

      while (pos < 1023) sd_byte(8'h00);
      @(negedge clk);
      fifo_almost_full = 1'b1;
      sd_byte(8'h00);
      repeat (20) @(negedge clk);
      chk("no_rd_while_fifo_full", 32'(rd_q.size()), 32'd0);
      chk("busy_while_throttled", 32'(busy), 32'd1);
      fifo_almost_full = 1'b0;
      @(negedge clk);
      chk("sd_rd_after_fifo_release", 32'(sd_rd), 32'd1);
      for (int i = 0; i < 50; i++) sd_byte(8'h00);

      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_sd_rd", 32'(sd_rd), 32'd0);
      chk("rst_sd_addr", sd_addr, 32'd0);
      chk("rst_d_out", 32'(d_out), 32'd0);
      chk("rst_d_ov", 32'(d_ov), 32'd0);
      chk("rst_region", 32'(region), 32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_sync_lost", 32'(sync_lost), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;

      // Leftover SD bytes after reset must be ignored.
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         sd_din = (i % 2 == 0) ? 8'hFF : 8'hFB;
         sd_iv  = 1'b1;
         @(negedge clk);
         sd_iv = 1'b0;
         repeat (3) @(negedge clk);
      end
      chk("no_rd_after_reset", 32'(rd_q.size()), 32'd0);

      pulse_start(32'd300, 32'd0);
      repeat (5) @(negedge clk);
      chk("zero_sectors_busy", 32'(busy), 32'd0);
      chk("zero_sectors_no_rd", 32'(rd_q.size()), 32'd0);

      pulse_start(32'd200, 32'd1);
      base = 32'd200; pos = 0;
      for (int i = 0; i < 511; i++) sd_byte(8'h00);
      chk("busy_before_last_byte", 32'(busy), 32'd1);
      sd_byte(8'h00);
      chk("busy_after_last_byte", 32'(busy), 32'd0);
      chk("no_extra_rd", 32'(rd_q.size()), 32'd0);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      chk("sync_lost_total", 32'(sl_cnt), 32'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
